// File: rtl/can_id_hopping_page_gen.sv
// ---------------------------------------------------------------------------
// can_id_hopping_page_gen
//
// Keyed page-address generator that drives the ID hopping table RAM. It holds
// the deployment key and the per-node message counter, and produces a 4-bit
// page address by seeding a 32-bit Galois LFSR with key ^ {cnt, ~cnt},
// stepping it ROUNDS times, and folding the eight nibbles together with XOR.
// Transmitter and receivers advance the counter on every completed hopped
// frame, so they hop in lock-step. A resync load realigns a receiver.
//
// Ports:
//   clk         system clock
//   rst         synchronous reset, active-high
//   key_in      deployment key, captured on key_load
//   key_load    pulse: load key, clear counter, start a computation
//   cnt_in      resync counter value, captured on cnt_load
//   cnt_load    pulse: load counter, compute only if a key is present
//   frame_done  pulse: hopped frame completed, increment counter
//   page_addr   page address to the hopping table (registered)
//   page_valid  page_addr matches the current counter (registered)
//   msg_cnt     current message counter
//   busy        computation in progress
// ---------------------------------------------------------------------------
module can_id_hopping_page_gen #(
   parameter int               KEY_W  = 32,
   parameter int               CNT_W  = 16,
   parameter int               ROUNDS = 4,
   parameter logic [KEY_W-1:0] POLY   = 32'h04C1_1DB7
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [KEY_W-1:0] key_in,
   input  logic             key_load,
   input  logic [CNT_W-1:0] cnt_in,
   input  logic             cnt_load,
   input  logic             frame_done,
   output logic [3:0]       page_addr,
   output logic             page_valid,
   output logic [CNT_W-1:0] msg_cnt,
   output logic             busy
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_SEED,
      S_MIX,
      S_DONE
   } state_t;

   state_t           r_state;
   logic [KEY_W-1:0] r_key;
   logic             r_key_valid;
   logic [CNT_W-1:0] r_msg_cnt;
   logic [KEY_W-1:0] r_s;
   logic [3:0]       r_rnd;
   logic [3:0]       r_page_addr;
   logic             r_page_valid;
   logic             r_busy;

   logic             w_start;
   logic [KEY_W-1:0] w_s_step;
   logic [3:0]       w_fold;

   // Any accepted event restarts the computation. cnt_load and frame_done
   // only matter once a key exists; a bare cnt_load still updates msg_cnt.
   assign w_start = key_load | ((cnt_load | frame_done) & r_key_valid);

   // One Galois LFSR step: shift left, fold in the polynomial when the
   // outgoing MSB was set.
   assign w_s_step = r_s[KEY_W-1] ? ({r_s[KEY_W-2:0], 1'b0} ^ POLY)
                                  :  {r_s[KEY_W-2:0], 1'b0};

   // NOTE: every signal written in always_comb gets a default assignment
   // first, so no path leaves it unassigned and no latch is inferred.
   always_comb begin
      w_fold = '0;
      for (int i = 0; i < KEY_W / 4; i++) begin
         w_fold = w_fold ^ r_s[4*i +: 4];
      end
   end

   // NOTE: state is updated with non-blocking assignments only, so every
   // register samples the pre-edge values of the others regardless of
   // statement order.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state      <= S_IDLE;
         r_key        <= '0;
         r_key_valid  <= 1'b0;
         r_msg_cnt    <= '0;
         r_s          <= '0;
         r_rnd        <= '0;
         r_page_addr  <= '0;
         r_page_valid <= 1'b0;
         r_busy       <= 1'b0;
      end else begin
         // Counter/key update: key_load > cnt_load > frame_done, only the
         // highest-priority event is applied.
         if (key_load) begin
            r_key       <= key_in;
            r_key_valid <= 1'b1;
            r_msg_cnt   <= '0;
         end else if (cnt_load) begin
            r_msg_cnt <= cnt_in;
         end else if (frame_done && r_key_valid) begin
            r_msg_cnt <= r_msg_cnt + 1'b1;
         end

         // An event in any busy state aborts and restarts from SEED; a
         // restart at the DONE edge leaves page_addr untouched.
         if (w_start) begin
            r_page_valid <= 1'b0;
            r_busy       <= 1'b1;
            r_state      <= S_SEED;
         end else begin
            unique case (r_state)
               S_IDLE: ;
               S_SEED: begin
                  // msg_cnt here already reflects the accepting edge.
                  r_s     <= r_key ^ {r_msg_cnt, ~r_msg_cnt};
                  r_rnd   <= '0;
                  r_state <= S_MIX;
               end
               S_MIX: begin
                  r_s   <= w_s_step;
                  r_rnd <= r_rnd + 4'd1;
                  if (r_rnd == 4'(ROUNDS - 1)) begin
                     r_state <= S_DONE;
                  end
               end
               S_DONE: begin
                  r_page_addr  <= w_fold;
                  r_page_valid <= 1'b1;
                  r_busy       <= 1'b0;
                  r_state      <= S_IDLE;
               end
               default: r_state <= S_IDLE;
            endcase
         end
      end
   end

   assign page_addr  = r_page_addr;
   assign page_valid = r_page_valid;
   assign msg_cnt    = r_msg_cnt;
   assign busy       = r_busy;

endmodule

// File: tb/tb_can_id_hopping_page_gen.sv
// ---------------------------------------------------------------------------
// Bench for can_id_hopping_page_gen. The driver applies one clock's worth of
// events per step and advances a behavioural model of key, counter and the
// pending computation; each started computation pushes its expected page
// and completion edge onto a scoreboard queue (aborted ones are withdrawn).
// A monitor on the falling edge compares msg_cnt/busy/page_valid every cycle
// and pops the queue on each page_valid rise.
// ---------------------------------------------------------------------------
module tb_can_id_hopping_page_gen;

   localparam int          ROUNDS  = 4;
   localparam logic [31:0] POLY    = 32'h04C1_1DB7;
   localparam int          LATENCY = ROUNDS + 2;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [31:0] key_in = '0;
   logic        key_load = 1'b0;
   logic [15:0] cnt_in = '0;
   logic        cnt_load = 1'b0;
   logic        frame_done = 1'b0;
   logic [3:0]  page_addr;
   logic        page_valid;
   logic [15:0] msg_cnt;
   logic        busy;

   can_id_hopping_page_gen #(
      .KEY_W (32),
      .CNT_W (16),
      .ROUNDS(ROUNDS),
      .POLY  (POLY)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .key_in    (key_in),
      .key_load  (key_load),
      .cnt_in    (cnt_in),
      .cnt_load  (cnt_load),
      .frame_done(frame_done),
      .page_addr (page_addr),
      .page_valid(page_valid),
      .msg_cnt   (msg_cnt),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [3:0] page;
      int         due;
   } exp_t;

   exp_t sb[$];

   int n_total = 0;
   int n_pass  = 0;

   // Behavioural model state, valid after each rising edge.
   logic [31:0] m_key     = '0;
   logic        m_kv      = 1'b0;
   logic [15:0] m_cnt     = '0;
   logic        m_pv      = 1'b0;
   logic        m_pending = 1'b0;
   int          m_due     = 0;
   int          edge_cnt  = 0;
   bit          mon_en    = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
   endtask

   // Page address straight from the arithmetic description: seed, step the
   // LFSR ROUNDS times, XOR the eight nibbles.
   function automatic logic [3:0] page_of(input logic [31:0] k, input logic [15:0] c);
      logic [31:0] s;
      logic [3:0]  p;
      s = k ^ {c, ~c};
      for (int r = 0; r < ROUNDS; r++) begin
         if (s[31]) s = (s << 1) ^ POLY;
         else       s = s << 1;
      end
      p = '0;
      for (int i = 0; i < 8; i++) p = p ^ s[4*i +: 4];
      return p;
   endfunction

   task automatic model_start();
      exp_t e;
      if (m_pending) void'(sb.pop_back());
      e.page = page_of(m_key, m_cnt);
      e.due  = edge_cnt + LATENCY;
      sb.push_back(e);
      m_pending = 1'b1;
      m_due     = e.due;
      m_pv      = 1'b0;
   endtask

   // Drive one cycle of inputs, let the DUT take them, advance the model.
   task automatic step(input logic r, input logic kl, input logic [31:0] kin,
                       input logic cl, input logic [15:0] cin, input logic fd);
      rst = r; key_load = kl; key_in = kin; cnt_load = cl; cnt_in = cin; frame_done = fd;
      @(posedge clk);
      edge_cnt++;
      if (r) begin
         m_key = '0; m_kv = 1'b0; m_cnt = '0; m_pv = 1'b0; m_pending = 1'b0;
         sb.delete();
      end else if (kl) begin
         m_key = kin; m_kv = 1'b1; m_cnt = '0;
         model_start();
      end else if (cl) begin
         m_cnt = cin;
         if (m_kv) model_start();
         else if (m_pending && edge_cnt == m_due) begin m_pending = 1'b0; m_pv = 1'b1; end
      end else if (fd && m_kv) begin
         m_cnt = m_cnt + 16'd1;
         model_start();
      end else if (m_pending && edge_cnt == m_due) begin
         m_pending = 1'b0;
         m_pv      = 1'b1;
      end
      #1;
      rst = 1'b0; key_load = 1'b0; cnt_load = 1'b0; frame_done = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) step(1'b0, 1'b0, '0, 1'b0, '0, 1'b0);
   endtask

   // Wait until just after the falling edge without consuming a rising edge.
   task automatic settle();
      @(negedge clk);
      #1;
   endtask

   // Monitor: per-cycle status compare plus scoreboard pop on valid rise.
   logic prev_pv = 1'b0;
   always @(negedge clk) begin
      if (mon_en) begin
         check("msg_cnt", 32'(msg_cnt), 32'(m_cnt));
         check("busy", 32'(busy), 32'(m_pending));
         check("page_valid", 32'(page_valid), 32'(m_pv));
         if (page_valid && !prev_pv) begin
            if (sb.size() == 0) begin
               check("unexpected_valid", 32'(1), 32'(0));
            end else begin
               exp_t e;
               e = sb.pop_front();
               check("page_addr", 32'(page_addr), 32'(e.page));
               check("latency_edge", 32'(edge_cnt), 32'(e.due));
            end
         end
         prev_pv = page_valid;
      end
   end

   initial begin
      // Reset and reset values.
      step(1'b1, 1'b0, '0, 1'b0, '0, 1'b0);
      mon_en = 1'b1;
      settle();
      check("rst_page_addr", 32'(page_addr), 32'h0);
      check("rst_page_valid", 32'(page_valid), 32'h0);

      // frame_done before any key is ignored.
      repeat (3) step(1'b0, 1'b0, '0, 1'b0, '0, 1'b1);
      settle();
      check("nokey_msg_cnt", 32'(msg_cnt), 32'h0);
      check("nokey_busy", 32'(busy), 32'h0);

      // Key 0, counter 0 -> page 0.
      step(1'b0, 1'b1, 32'h0000_0000, 1'b0, '0, 1'b0);
      idle(LATENCY);
      settle();
      check("key0_page", 32'(page_addr), 32'h0);
      check("key0_valid", 32'(page_valid), 32'h1);

      // Key 1 -> seed 0000_FFFE -> 000F_FFE0 -> page 1.
      step(1'b0, 1'b1, 32'h0000_0001, 1'b0, '0, 1'b0);
      idle(LATENCY);
      settle();
      check("key1_page", 32'(page_addr), 32'h1);

      // Key 0, one frame -> counter 1, seed 0001_FFFE -> page 0.
      step(1'b0, 1'b1, 32'h0000_0000, 1'b0, '0, 1'b0);
      idle(LATENCY);
      step(1'b0, 1'b0, '0, 1'b0, '0, 1'b1);
      idle(LATENCY);
      settle();
      check("cnt1_msg_cnt", 32'(msg_cnt), 32'h1);
      check("cnt1_page", 32'(page_addr), 32'h0);

      // Counter wrap FFFF -> 0 gives the counter-0 result.
      step(1'b0, 1'b0, '0, 1'b1, 16'hFFFF, 1'b0);
      idle(LATENCY);
      step(1'b0, 1'b0, '0, 1'b0, '0, 1'b1);
      idle(LATENCY);
      settle();
      check("wrap_msg_cnt", 32'(msg_cnt), 32'h0);
      check("wrap_page", 32'(page_addr), 32'h0);

      // Restart mid-computation: second frame_done three cycles later.
      step(1'b0, 1'b0, '0, 1'b0, '0, 1'b1);
      idle(2);
      step(1'b0, 1'b0, '0, 1'b0, '0, 1'b1);
      idle(LATENCY);
      settle();
      check("restart_msg_cnt", 32'(msg_cnt), 32'h2);

      // key_load wins over a simultaneous frame_done.
      step(1'b0, 1'b1, 32'h1234_5678, 1'b0, '0, 1'b1);
      idle(LATENCY);
      settle();
      check("kl_fd_msg_cnt", 32'(msg_cnt), 32'h0);

      // Reset during MIX, then frame_done is ignored again.
      step(1'b0, 1'b0, '0, 1'b0, '0, 1'b1);
      idle(3);
      step(1'b1, 1'b0, '0, 1'b0, '0, 1'b0);
      settle();
      check("midrst_page_addr", 32'(page_addr), 32'h0);
      check("midrst_busy", 32'(busy), 32'h0);
      step(1'b0, 1'b0, '0, 1'b0, '0, 1'b1);
      settle();
      check("midrst_fd_ignored", 32'(msg_cnt), 32'h0);

      // Randomized traffic, including overlapping events and rare resets.
      for (int i = 0; i < 600; i++) begin
         logic        r, kl, cl, fd;
         logic [31:0] kin;
         logic [15:0] cin;
         r   = ($urandom_range(0, 199) == 0);
         kl  = ($urandom_range(0, 19) == 0);
         cl  = ($urandom_range(0, 14) == 0);
         fd  = ($urandom_range(0, 7) == 0);
         kin = $urandom;
         cin = ($urandom_range(0, 3) == 0) ? 16'hFFFF : 16'($urandom);
         step(r, kl, kin, cl, cin, fd);
         if (i % 50 == 49) idle(LATENCY + 2);
      end
      idle(LATENCY + 4);
      settle();
      check("scoreboard_drained", 32'(sb.size()), 32'h0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/can_id_hopping_page_gen.md
Name: can_id_hopping_page_gen

Overview:
Keyed page-address generator directly upstream of the ID hopping table RAM. It holds the deployment key and the per-node message counter, and derives the 4-bit hopping-table page address from them. The result drives the table's page-address input for both the transmit lookup and the receive reverse lookup. The counter advances once per completed hopped frame, so transmitter and receivers hop in lock-step; a resync load realigns a receiver's counter.

Parameters:
KEY_W, 32, key and mixing-state width (fixed 32; mixing polynomial is 32-bit)
CNT_W, 16, message counter width; seed uses {cnt, ~cnt}, so 2*CNT_W must equal KEY_W
ROUNDS, 4, LFSR mixing steps per computation (1..15)
POLY, 32'h04C11DB7, Galois LFSR feedback polynomial

Ports:
clk  input  1  system clock
rst  input  1  synchronous reset, active-high
key_in  input  32  deployment key
key_load  input  1  1-cycle pulse: load key_in, clear counter, start compute
cnt_in  input  16  resync counter value
cnt_load  input  1  1-cycle pulse: load cnt_in, start compute
frame_done  input  1  1-cycle pulse: hopped frame completed (tx or rx), increment counter
page_addr  output  4  page address to the ID hopping table
page_valid  output  1  page_addr valid for the current counter
msg_cnt  output  16  current message counter
busy  output  1  computation in progress

Behaviour:
- Clock and reset: single clock clk; rst is synchronous, active-high.
- Reset values: page_addr=0, page_valid=0, msg_cnt=0, busy=0, key=0, key_valid=0, state=IDLE.
- Event priority when asserted in the same cycle: key_load > cnt_load > frame_done. Only the highest-priority event is applied; the others are dropped.
- key_load: key<=key_in, key_valid<=1, msg_cnt<=0, start compute.
- cnt_load: msg_cnt<=cnt_in. Starts compute only if key_valid=1.
- frame_done: ignored while key_valid=0. Otherwise msg_cnt<=msg_cnt+1, mod 2^16, so 16'hFFFF wraps to 0; then start compute.
- Start compute, at the accepting edge E: page_valid<=0, busy<=1, state<=SEED. page_addr holds its old value.
- FSM states: IDLE, SEED, MIX, DONE.
  - SEED, edge E+1: s<=key ^ {msg_cnt, ~msg_cnt}; rnd<=0; ->MIX.
  - MIX: each edge, s<=s[31] ? ({s[30:0],1'b0}^POLY) : {s[30:0],1'b0}; rnd<=rnd+1. After the ROUNDS-th step, ->DONE.
  - DONE, edge E+ROUNDS+2: page_addr<=XOR of the eight nibbles of s; page_valid<=1; busy<=0; ->IDLE.
- Latency: page_valid rises ROUNDS+2 clocks after the accepting edge (6 with defaults).
- Event during SEED/MIX/DONE: apply the event, abort the current computation and restart from SEED. A restart from DONE does not update page_addr. page_valid stays 0 throughout.
- page_addr and page_valid are registered and change only at the DONE edge or on rst.
- msg_cnt is visible the cycle after its update edge.
- rst mid-computation: everything returns to reset values and key_valid=0. A later frame_done is ignored until the next key_load.

Test Plan:
- Reset, then key_load with key_in=32'h0000_0000 -> msg_cnt=0; busy=1 for 6 cycles; page_valid=1 at 6 cycles after the load edge with page_addr=4'h0.
- key_load key_in=32'h0000_0001 -> seed 32'h0000_FFFE, after 4 rounds 32'h000F_FFE0 -> page_addr=4'h1, page_valid=1.
- With key 0 loaded, one frame_done -> msg_cnt=1; seed 32'h0001_FFFE -> page_addr=4'h0 after 6 cycles; page_valid low during those 6 cycles.
- cnt_load cnt_in=16'hFFFF, then frame_done -> msg_cnt=16'h0000 (wrap); recomputation identical to the counter=0 result.
- frame_done at cycle 3 of a computation -> restart; msg_cnt incremented once; page_valid rises 6 cycles after the second event, not the first. Simultaneous key_load+frame_done -> msg_cnt=0.
- Before any key_load, frame_done pulses -> msg_cnt stays 0, page_valid=0, busy=0. Assert rst during MIX -> all outputs return to reset values next cycle.
